nzcv_flag_reg: RTL and testbench
================================

# nzcv_flag_reg

Architectural condition-flag register for the ARM core: holds the current NZCV, applies flag writes from the execute stage, MSR-style direct writes, and exception save/restore. It sits directly upstream of `NZCV_CHECK`. It drives both the registered flags and a same-cycle forwarded value, so the condition check of the following instruction always sees the latest flags.

## Interface
Parameters:
- `RESET_FLAGS`, default `4'b0000`: value loaded into `NZCV` and `SAVED_NZCV` on reset.

Ports:
- `CLK` input 1: single clock; all state updates on the rising edge.
- `RST_N` input 1: asynchronous, active-low reset.
- `STALL` input 1: pipeline stall; when high, no state changes.
- `EX_VALID` input 1: execute-stage instruction valid this cycle.
- `EX_COND_PASS` input 1: `NZCV_CHECK` `OUT` for this instruction.
- `EX_S` input 1: instruction's S bit (set flags).
- `EX_FLAG_WE` input 4: per-bit write enable, in order [N,Z,C,V]. Logical ops assert `4'b1110`; arithmetic ops assert `4'b1111`.
- `ALU_NZCV` input 4: flags produced by the ALU/shifter.
- `MSR_WE` input 1: direct flag write.
- `MSR_DATA` input 4: value for a direct write.
- `EXC_ENTRY` input 1: exception entry; save the current flags.
- `EXC_RETURN` input 1: exception return; restore the saved flags.
- `NZCV` output 4: registered architectural flags; feeds `NZCV_CHECK.NZCV`.
- `NZCV_FWD` output 4: combinational next-state value; used for back-to-back condition checks.
- `SAVED_NZCV` output 4: saved copy of the flags (SPSR flag field).
- `IN_EXC` output 1: high while the FSM is in EXC.
- `EXC_ERR` output 1: sticky error flag; set on a protocol violation, cleared only by reset.

## Operation
- FSM has two states: NORM and EXC. Reset state is NORM.
- Event priority within one cycle, highest first: `EXC_ENTRY`, `EXC_RETURN`, `MSR_WE`, ALU update. Exactly one event takes effect; lower-priority events that cycle are dropped.
- ALU update: occurs when `EX_VALID & EX_COND_PASS & EX_S`. For each bit i: `next[i] = EX_FLAG_WE[i] ? ALU_NZCV[i] : NZCV[i]`.
  - `EX_COND_PASS=0` or `EX_S=0` leaves the flags unchanged.
- MSR: `next = MSR_DATA`, all four bits.
- `EXC_ENTRY` in NORM:
  - `SAVED_NZCV <= NZCV` (the pre-update value); `NZCV` is unchanged.
  - FSM goes NORM→EXC.
- `EXC_ENTRY` in EXC (nested): ignored. `EXC_ERR <= 1`; `SAVED_NZCV` is not overwritten.
- `EXC_RETURN` in EXC: `NZCV <= SAVED_NZCV`; FSM goes EXC→NORM.
- `EXC_RETURN` in NORM: ignored; `EXC_ERR <= 1`.
- In EXC, ALU and MSR updates still apply to `NZCV`. `SAVED_NZCV` is modified only by `EXC_ENTRY`.
- `STALL=1` has the highest priority over every event:
  - all registers hold;
  - `NZCV_FWD = NZCV`;
  - events presented during the stall are not remembered.
- `NZCV_FWD` is the value `NZCV` will take at the next edge, given the current inputs.

## Timing
- Reset (asynchronous, takes effect immediately on `RST_N` low):
  - `NZCV` = `SAVED_NZCV` = `RESET_FLAGS`;
  - `IN_EXC` = 0, `EXC_ERR` = 0, FSM = NORM;
  - `NZCV_FWD` = `RESET_FLAGS` while `RST_N` is low.
- Update latency:
  - `NZCV` reflects an event one cycle after the event's edge;
  - `NZCV_FWD` reflects it in the same cycle, combinationally.
- Back-to-back flag-setting instructions: the second instruction's condition check must use `NZCV_FWD`. The block's obligation is only that `NZCV_FWD` is correct every cycle.
- Reset mid-exception: the saved flags are lost; the FSM returns to NORM.
- Purely combinational paths: inputs → `NZCV_FWD` only. All other outputs are registered.

## Structure
- Shared package `arm_pkg` holds:
  - flag bit indices `FLAG_N=3`, `FLAG_Z=2`, `FLAG_C=1`, `FLAG_V=0`;
  - the FSM state type with encodings NORM=1'b0, EXC=1'b1;
  - constants `FWE_LOGIC=4'b1110` and `FWE_ARITH=4'b1111`.
- No sub-module: the block is one next-state mux plus the FSM. It does not instantiate `NZCV_CHECK`; the top level connects `NZCV`/`NZCV_FWD` to it.

## Test plan
- Reset: drive `RST_N=0` mid-cycle with `RESET_FLAGS=4'b0000` → `NZCV=0000`, `SAVED_NZCV=0000`, `IN_EXC=0`, `EXC_ERR=0` asynchronously, before the next edge.
- ALU masking: `NZCV=0101`; apply `EX_VALID=1`, `EX_COND_PASS=1`, `EX_S=1`, `EX_FLAG_WE=1110`, `ALU_NZCV=1010`:
  - `NZCV_FWD=1011` in the same cycle;
  - `NZCV=1011` after the edge.
  - Repeat with `EX_COND_PASS=0` → `NZCV` stays `1011`.
- Priority: same cycle `MSR_WE=1`, `MSR_DATA=0110`, plus a valid ALU update with `ALU_NZCV=1111` and `EX_FLAG_WE=1111` → `NZCV=0110`.
- Exception round trip:
  - `NZCV=1001`, pulse `EXC_ENTRY` → `SAVED_NZCV=1001`, `IN_EXC=1`;
  - MSR writes `0010` → `NZCV=0010`;
  - pulse `EXC_RETURN` → `NZCV=1001`, `IN_EXC=0`.
- Protocol errors:
  - `EXC_RETURN` in NORM → `EXC_ERR=1`, `NZCV` unchanged;
  - nested `EXC_ENTRY` with `NZCV=0100` after saving `1100` → `SAVED_NZCV` stays `1100`;
  - `EXC_ERR` stays 1 until reset.
- Stall: hold `STALL=1` with `MSR_WE=1`, `MSR_DATA=1111` for 3 cycles → `NZCV` and `NZCV_FWD` unchanged. Release the stall with `MSR_WE=0` → `NZCV` still unchanged.

Source files
------------

// File: rtl/arm_pkg.sv
// ---------------------------------------------------------------------------
// arm_pkg
// Shared definitions for the ARM core's condition-flag logic:
//   - bit positions of N, Z, C and V inside a 4-bit NZCV vector
//   - the state type of the flag-register FSM
//   - the per-bit flag write-enable patterns the execute stage uses
//   - merge_flags(): applies a masked ALU flag write to the current flags
// ---------------------------------------------------------------------------
package arm_pkg;

    // Bit positions inside a 4-bit NZCV vector.
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Flag write-enable patterns. Logical ops leave V alone.
    localparam logic [3:0] FWE_LOGIC = 4'b1110;
    localparam logic [3:0] FWE_ARITH = 4'b1111;

    // NORM: normal execution. EXC: inside an exception handler, with the
    // interrupted context's flags held in the saved copy.
    typedef enum logic {
        NORM = 1'b0,
        EXC  = 1'b1
    } fsm_state_e;

    // Each flag takes the ALU value where its enable is set, and keeps its
    // current value otherwise.
    function automatic logic [3:0] merge_flags(
        input logic [3:0] cur,
        input logic [3:0] alu,
        input logic [3:0] we
    );
        logic [3:0] res;
        res[FLAG_N] = we[FLAG_N] ? alu[FLAG_N] : cur[FLAG_N];
        res[FLAG_Z] = we[FLAG_Z] ? alu[FLAG_Z] : cur[FLAG_Z];
        res[FLAG_C] = we[FLAG_C] ? alu[FLAG_C] : cur[FLAG_C];
        res[FLAG_V] = we[FLAG_V] ? alu[FLAG_V] : cur[FLAG_V];
        return res;
    endfunction

endpackage : arm_pkg

// File: rtl/nzcv_flag_reg.sv
// ---------------------------------------------------------------------------
// nzcv_flag_reg
// The architectural condition-flag register. It holds the current NZCV and
// applies, in priority order, exception entry, exception return, MSR-style
// direct writes and masked ALU flag writes. It also provides a combinational
// forward of the next flag value, so the condition check of the next
// instruction can see flags written by the instruction just before it.
//
// Parameters:
//   RESET_FLAGS   value loaded into NZCV and SAVED_NZCV on reset
// Ports:
//   CLK           clock; all state updates happen on the rising edge
//   RST_N         asynchronous active-low reset
//   STALL         pipeline stall: every register holds and events are dropped
//   EX_VALID      execute-stage instruction is valid this cycle
//   EX_COND_PASS  the instruction's condition check passed
//   EX_S          the instruction's S bit (set flags)
//   EX_FLAG_WE    per-flag write enable, ordered [N,Z,C,V]
//   ALU_NZCV      flags produced by the ALU/shifter
//   MSR_WE        direct flag write
//   MSR_DATA      value for the direct write
//   EXC_ENTRY     exception entry: save the current flags
//   EXC_RETURN    exception return: restore the saved flags
//   NZCV          registered architectural flags
//   NZCV_FWD      value NZCV takes at the next edge (combinational)
//   SAVED_NZCV    saved copy of the flags (SPSR flag field)
//   IN_EXC        high while the FSM is in EXC
//   EXC_ERR       sticky protocol-violation flag, cleared only by reset
// ---------------------------------------------------------------------------
module nzcv_flag_reg
    import arm_pkg::*;
#(
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       STALL,
    input  logic       EX_VALID,
    input  logic       EX_COND_PASS,
    input  logic       EX_S,
    input  logic [3:0] EX_FLAG_WE,
    input  logic [3:0] ALU_NZCV,
    input  logic       MSR_WE,
    input  logic [3:0] MSR_DATA,
    input  logic       EXC_ENTRY,
    input  logic       EXC_RETURN,
    output logic [3:0] NZCV,
    output logic [3:0] NZCV_FWD,
    output logic [3:0] SAVED_NZCV,
    output logic       IN_EXC,
    output logic       EXC_ERR
);

    fsm_state_e state_q, state_d;
    logic [3:0] nzcv_q, nzcv_d;
    logic [3:0] saved_q, saved_d;
    logic       exc_err_q, exc_err_d;
    logic       alu_upd;

    assign alu_upd = EX_VALID & EX_COND_PASS & EX_S;

    // One event takes effect per cycle. A protocol violation still consumes
    // its cycle: the lower-priority events presented with it are dropped.
    always_comb begin
        // NOTE: every signal written here gets a default before any branch,
        // so no path leaves a value unassigned and no latch is inferred.
        state_d   = state_q;
        nzcv_d    = nzcv_q;
        saved_d   = saved_q;
        exc_err_d = exc_err_q;

        if (!STALL) begin
            if (EXC_ENTRY) begin
                if (state_q == NORM) begin
                    saved_d = nzcv_q;
                    state_d = EXC;
                end else begin
                    // Nested entry: the saved context must not be clobbered.
                    exc_err_d = 1'b1;
                end
            end else if (EXC_RETURN) begin
                if (state_q == EXC) begin
                    nzcv_d  = saved_q;
                    state_d = NORM;
                end else begin
                    exc_err_d = 1'b1;
                end
            end else if (MSR_WE) begin
                nzcv_d = MSR_DATA;
            end else if (alu_upd) begin
                nzcv_d = merge_flags(nzcv_q, ALU_NZCV, EX_FLAG_WE);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= NORM;
            nzcv_q    <= RESET_FLAGS;
            saved_q   <= RESET_FLAGS;
            exc_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            nzcv_q    <= nzcv_d;
            saved_q   <= saved_d;
            exc_err_q <= exc_err_d;
        end
    end

    // While reset is held the registers sit at RESET_FLAGS regardless of the
    // inputs, so the forward must report that too rather than nzcv_d.
    assign NZCV_FWD   = RST_N ? nzcv_d : RESET_FLAGS;
    assign NZCV       = nzcv_q;
    assign SAVED_NZCV = saved_q;
    assign IN_EXC     = (state_q == EXC);
    assign EXC_ERR    = exc_err_q;

endmodule : nzcv_flag_reg

// File: tb/tb_nzcv_flag_reg.sv
// ---------------------------------------------------------------------------
// tb_nzcv_flag_reg
// Self-checking bench for nzcv_flag_reg: directed scenarios with literal
// expectations, then randomized traffic. A behavioural model tracks the
// architectural state; a compare process checks every DUT output against it
// on each falling edge. Inputs change 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_nzcv_flag_reg;
    import arm_pkg::*;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       STALL, EX_VALID, EX_COND_PASS, EX_S, MSR_WE, EXC_ENTRY, EXC_RETURN;
    logic [3:0] EX_FLAG_WE, ALU_NZCV, MSR_DATA;
    logic [3:0] NZCV, NZCV_FWD, SAVED_NZCV;
    logic       IN_EXC, EXC_ERR;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    nzcv_flag_reg #(.RESET_FLAGS(4'b0000)) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .STALL        (STALL),
        .EX_VALID     (EX_VALID),
        .EX_COND_PASS (EX_COND_PASS),
        .EX_S         (EX_S),
        .EX_FLAG_WE   (EX_FLAG_WE),
        .ALU_NZCV     (ALU_NZCV),
        .MSR_WE       (MSR_WE),
        .MSR_DATA     (MSR_DATA),
        .EXC_ENTRY    (EXC_ENTRY),
        .EXC_RETURN   (EXC_RETURN),
        .NZCV         (NZCV),
        .NZCV_FWD     (NZCV_FWD),
        .SAVED_NZCV   (SAVED_NZCV),
        .IN_EXC       (IN_EXC),
        .EXC_ERR      (EXC_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: architectural flags, saved copy, mode, error.
    // ------------------------------------------------------------------
    logic [3:0] m_nzcv  = 4'b0000;
    logic [3:0] m_saved = 4'b0000;
    bit         m_exc   = 1'b0;
    bit         m_err   = 1'b0;

    // Flags after the coming edge, from the model state and current inputs.
    function automatic logic [3:0] model_next_flags();
        logic [3:0] r;
        if (!RST_N)      return 4'b0000;
        if (STALL)       return m_nzcv;
        if (EXC_ENTRY)   return m_nzcv;
        if (EXC_RETURN)  return m_exc ? m_saved : m_nzcv;
        if (MSR_WE)      return MSR_DATA;
        if (!(EX_VALID && EX_COND_PASS && EX_S)) return m_nzcv;
        for (int i = 0; i < 4; i++)
            r[i] = EX_FLAG_WE[i] ? ALU_NZCV[i] : m_nzcv[i];
        return r;
    endfunction

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m_nzcv = 4'b0000; m_saved = 4'b0000; m_exc = 1'b0; m_err = 1'b0;
        end else if (!STALL) begin
            logic [3:0] nxt;
            nxt = model_next_flags();
            if (EXC_ENTRY) begin
                if (m_exc) m_err = 1'b1;
                else begin m_saved = m_nzcv; m_exc = 1'b1; end
            end else if (EXC_RETURN) begin
                if (m_exc) m_exc = 1'b0;
                else m_err = 1'b1;
            end
            m_nzcv = nxt;
        end
    end

    // Compare process: every output against the model, once per cycle.
    always @(negedge CLK) begin
        if (cmp_en) begin
            check("cmp NZCV",       NZCV,          m_nzcv);
            check("cmp NZCV_FWD",   NZCV_FWD,      model_next_flags());
            check("cmp SAVED_NZCV", SAVED_NZCV,    m_saved);
            check("cmp IN_EXC",     {3'b0, IN_EXC},  {3'b0, m_exc});
            check("cmp EXC_ERR",    {3'b0, EXC_ERR}, {3'b0, m_err});
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic idle();
        STALL = 0; EX_VALID = 0; EX_COND_PASS = 0; EX_S = 0; EX_FLAG_WE = 4'b0000;
        ALU_NZCV = 4'b0000; MSR_WE = 0; MSR_DATA = 4'b0000; EXC_ENTRY = 0; EXC_RETURN = 0;
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic msr(input logic [3:0] d);
        idle(); MSR_WE = 1; MSR_DATA = d;
        cycle(); idle();
    endtask

    task automatic pulse_entry();
        idle(); EXC_ENTRY = 1;
        cycle(); idle();
    endtask

    task automatic pulse_return();
        idle(); EXC_RETURN = 1;
        cycle(); idle();
    endtask

    initial begin
        idle();
        RST_N = 1'b0;
        #12;
        check("reset NZCV", NZCV, 4'b0000);
        check("reset SAVED", SAVED_NZCV, 4'b0000);
        check("reset IN_EXC/EXC_ERR", {2'b0, IN_EXC, EXC_ERR}, 4'b0000);
        @(posedge CLK); #1;
        RST_N = 1'b1;
        cmp_en = 1'b1;
        cycle();

        // ALU masking: 0101 with logic-op write of 1010 -> 1011.
        msr(4'b0101);
        check("msr 0101", NZCV, 4'b0101);
        EX_VALID = 1; EX_COND_PASS = 1; EX_S = 1; EX_FLAG_WE = FWE_LOGIC; ALU_NZCV = 4'b1010;
        #1;
        check("alu mask fwd", NZCV_FWD, 4'b1011);
        cycle();
        check("alu mask reg", NZCV, 4'b1011);
        EX_COND_PASS = 0; ALU_NZCV = 4'b0000; EX_FLAG_WE = FWE_ARITH;
        #1;
        check("cond fail fwd", NZCV_FWD, 4'b1011);
        cycle();
        check("cond fail reg", NZCV, 4'b1011);
        idle();

        // MSR beats a simultaneous ALU update.
        MSR_WE = 1; MSR_DATA = 4'b0110;
        EX_VALID = 1; EX_COND_PASS = 1; EX_S = 1; EX_FLAG_WE = FWE_ARITH; ALU_NZCV = 4'b1111;
        cycle(); idle();
        check("msr over alu", NZCV, 4'b0110);

        // Exception round trip.
        msr(4'b1001);
        pulse_entry();
        check("entry saved", SAVED_NZCV, 4'b1001);
        check("entry in_exc", {3'b0, IN_EXC}, 4'b0001);
        check("entry nzcv held", NZCV, 4'b1001);
        msr(4'b0010);
        check("msr in exc", NZCV, 4'b0010);
        pulse_return();
        check("return restore", NZCV, 4'b1001);
        check("return in_exc", {3'b0, IN_EXC}, 4'b0000);

        // Protocol errors.
        pulse_return();
        check("stray return err", {3'b0, EXC_ERR}, 4'b0001);
        check("stray return nzcv", NZCV, 4'b1001);
        msr(4'b1100);
        pulse_entry();
        msr(4'b0100);
        pulse_entry();
        check("nested saved kept", SAVED_NZCV, 4'b1100);
        check("nested in_exc", {3'b0, IN_EXC}, 4'b0001);
        check("nested nzcv", NZCV, 4'b0100);

        // Stall: a held MSR write must not land, during or after the stall.
        STALL = 1; MSR_WE = 1; MSR_DATA = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall fwd", NZCV_FWD, 4'b0100);
            cycle();
            check("stall reg", NZCV, 4'b0100);
        end
        idle();
        cycle();
        check("post stall reg", NZCV, 4'b0100);
        check("err sticky", {3'b0, EXC_ERR}, 4'b0001);

        // Asynchronous reset mid-cycle, with an MSR write pending.
        MSR_WE = 1; MSR_DATA = 4'b1111;
        #2;
        RST_N = 1'b0;
        #1;
        check("async NZCV", NZCV, 4'b0000);
        check("async FWD", NZCV_FWD, 4'b0000);
        check("async SAVED", SAVED_NZCV, 4'b0000);
        check("async IN_EXC/EXC_ERR", {2'b0, IN_EXC, EXC_ERR}, 4'b0000);
        cycle();
        idle();
        RST_N = 1'b1;
        cycle();

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            STALL        = ($urandom_range(0, 7) == 0);
            EXC_ENTRY    = ($urandom_range(0, 11) == 0);
            EXC_RETURN   = ($urandom_range(0, 11) == 0);
            MSR_WE       = ($urandom_range(0, 5) == 0);
            MSR_DATA     = 4'($urandom);
            EX_VALID     = ($urandom_range(0, 1) == 1);
            EX_COND_PASS = ($urandom_range(0, 3) != 0);
            EX_S         = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 2))
                0:       EX_FLAG_WE = FWE_LOGIC;
                1:       EX_FLAG_WE = FWE_ARITH;
                default: EX_FLAG_WE = 4'($urandom);
            endcase
            ALU_NZCV = 4'($urandom);
            RST_N    = ($urandom_range(0, 299) != 0);
            cycle();
        end
        RST_N = 1'b1;
        idle();
        cycle();
        cmp_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_nzcv_flag_reg
